// File: rtl/i_cache_assoc_pkg.sv
// Shared types and field-width helpers for the set-associative instruction cache.
package i_cache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS     = 2'd1,
    FILL     = 2'd2,
    END_FILL = 2'd3
  } state_e;

  // kseg1 is the unmapped, uncached window at 0xA000_0000..0xBFFF_FFFF
  localparam logic [2:0] KSEG1_PREFIX = 3'b101;

  function automatic int offset_width(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int tag_width(input int index_width, input int line_words);
    return 32 - index_width - offset_width(line_words);
  endfunction

endpackage

// File: rtl/i_cache_assoc_if.sv
// Fetch-stage and AXI read-channel signals of the instruction cache.
interface i_cache_assoc_if;

  logic        cpu_inst_req;
  logic [31:0] cpu_inst_addr;
  logic        longest_stall;
  logic        inv_all;
  logic [31:0] cpu_inst_rdata;
  logic        i_stall;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // master is the cache itself; slave is the core plus the read arbiter
  modport master (
    input  cpu_inst_req, cpu_inst_addr, longest_stall, inv_all,
    input  arready, rdata, rlast, rvalid,
    output cpu_inst_rdata, i_stall, araddr, arlen, arvalid, rready
  );

  modport slave (
    output cpu_inst_req, cpu_inst_addr, longest_stall, inv_all,
    output arready, rdata, rlast, rvalid,
    input  cpu_inst_rdata, i_stall, araddr, arlen, arvalid, rready
  );

endinterface

// File: rtl/i_cache_way.sv
// One way of the cache: valid, tag and line arrays with a combinational read
// port, a single line write port and a whole-way valid clear.
module i_cache_way
  import i_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 7,
  parameter int LINE_WORDS  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear_all,
  input  logic [INDEX_WIDTH-1:0]            rd_index,
  output logic                              rd_valid,
  output logic [tag_width(INDEX_WIDTH, LINE_WORDS)-1:0] rd_tag,
  output logic [LINE_WORDS-1:0][31:0]       rd_line,
  input  logic                              we,
  input  logic [INDEX_WIDTH-1:0]            wr_index,
  input  logic [tag_width(INDEX_WIDTH, LINE_WORDS)-1:0] wr_tag,
  input  logic [LINE_WORDS-1:0][31:0]       wr_line
);

  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int TAG_W = tag_width(INDEX_WIDTH, LINE_WORDS);

  logic [SETS-1:0]             valid_q, valid_d;
  logic [TAG_W-1:0]            tag_q [SETS];
  logic [TAG_W-1:0]            tag_d [SETS];
  logic [LINE_WORDS-1:0][31:0] data_mem [SETS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (clear_all) begin
      valid_d = '0;
    end else if (we) begin
      valid_d[wr_index] = 1'b1;
    end
    if (we) begin
      tag_d[wr_index] = wr_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  // line storage is plain memory; only valid bits gate its use
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/i_cache_assoc.sv
// Set-associative instruction cache: hit mux, miss FSM with fill buffer,
// per-set round-robin replacement, whole-cache invalidate and kseg1 bypass.
module i_cache_assoc
  import i_cache_pkg::*;
#(
  parameter int WAYS           = 2,
  parameter int INDEX_WIDTH    = 7,
  parameter int LINE_WORDS     = 8,
  parameter int UNCACHED_KSEG1 = 1
) (
  input  logic       clk,
  input  logic       rst,
  i_cache_assoc_if.master bus
);

  localparam int SETS   = 1 << INDEX_WIDTH;
  localparam int OFF_W  = offset_width(LINE_WORDS);
  localparam int WORD_W = OFF_W - 2;
  localparam int TAG_W  = tag_width(INDEX_WIDTH, LINE_WORDS);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e                      state_q, state_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic [31:0]                 req_addr_q, req_addr_d;
  logic                        uncached_q, uncached_d;
  logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic [LINE_WORDS-1:0][31:0] buffer_q, buffer_d;
  logic                        inv_pending_q, inv_pending_d;
  logic [RR_W-1:0]             rr_ptr_q [SETS];
  logic [RR_W-1:0]             rr_ptr_d [SETS];

  logic [TAG_W-1:0]       cpu_tag, req_tag;
  logic [INDEX_WIDTH-1:0] cpu_index, req_index, look_index;
  logic [WORD_W-1:0]      cpu_word, req_word;
  logic                   cpu_uncached;

  assign cpu_tag      = bus.cpu_inst_addr[31 -: TAG_W];
  assign cpu_index    = bus.cpu_inst_addr[OFF_W +: INDEX_WIDTH];
  assign cpu_word     = bus.cpu_inst_addr[2 +: WORD_W];
  assign req_tag      = req_addr_q[31 -: TAG_W];
  assign req_index    = req_addr_q[OFF_W +: INDEX_WIDTH];
  assign req_word     = req_addr_q[2 +: WORD_W];
  assign cpu_uncached = (UNCACHED_KSEG1 != 0) && (bus.cpu_inst_addr[31:29] == KSEG1_PREFIX);

  // outside IDLE the ways are looked up at the latched miss set for victim choice
  assign look_index = (state_q == IDLE) ? cpu_index : req_index;

  logic [WAYS-1:0]             way_valid;
  logic [TAG_W-1:0]            way_tag  [WAYS];
  logic [LINE_WORDS-1:0][31:0] way_line [WAYS];
  logic [WAYS-1:0]             way_we;
  logic                        clear_all;

  logic                        inv_block, hit_any, hit;
  logic [LINE_WORDS-1:0][31:0] hit_line;
  logic [RR_W-1:0]             victim;
  logic                        found_free, set_full;
  logic                        commit, commit_write;
  logic [31:0]                 cpu_rdata;

  assign inv_block    = bus.inv_all || inv_pending_q;
  assign set_full     = &way_valid;
  assign commit       = (state_q == END_FILL) && !bus.longest_stall;
  assign commit_write = commit && !uncached_q && !inv_block;
  assign clear_all    = (bus.inv_all && (state_q == IDLE)) || (commit && inv_block);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = commit_write && (victim == RR_W'(w));

    i_cache_way #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .LINE_WORDS  (LINE_WORDS)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .clear_all (clear_all),
      .rd_index  (look_index),
      .rd_valid  (way_valid[w]),
      .rd_tag    (way_tag[w]),
      .rd_line   (way_line[w]),
      .we        (way_we[w]),
      .wr_index  (req_index),
      .wr_tag    (req_tag),
      .wr_line   (buffer_q)
    );
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == cpu_tag)) begin
        hit_any  = 1'b1;
        hit_line = way_line[w];
      end
    end
    hit = bus.cpu_inst_req && !cpu_uncached && !inv_block && hit_any;
  end

  // lowest invalid way wins; a full set falls back to its round-robin pointer
  always_comb begin
    victim     = rr_ptr_q[req_index];
    found_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !way_valid[w]) begin
        victim     = RR_W'(w);
        found_free = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (bus.inv_all && (state_q == IDLE)) begin
      rr_ptr_d = '{default: '0};
    end else if (commit_write && set_full) begin
      rr_ptr_d[req_index] = (rr_ptr_q[req_index] == RR_W'(WAYS - 1)) ? '0
                                                                      : rr_ptr_q[req_index] + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    req_addr_d    = req_addr_q;
    uncached_d    = uncached_q;
    beat_cnt_d    = beat_cnt_q;
    buffer_d      = buffer_q;
    inv_pending_d = inv_pending_q;
    if (bus.inv_all && (state_q != IDLE)) begin
      inv_pending_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_inst_req && !hit) begin
          state_d    = MISS;
          arvalid_d  = 1'b1;
          req_addr_d = bus.cpu_inst_addr;
          uncached_d = cpu_uncached;
          beat_cnt_d = '0;
        end
      end
      MISS: begin
        if (bus.arready) begin
          state_d   = FILL;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      FILL: begin
        if (bus.rvalid) begin
          buffer_d[beat_cnt_q] = bus.rdata;
          beat_cnt_d           = beat_cnt_q + 1'b1;
          if (bus.rlast) begin
            state_d  = END_FILL;
            rready_d = 1'b0;
          end
        end
      end
      END_FILL: begin
        if (!bus.longest_stall) begin
          state_d       = IDLE;
          inv_pending_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      req_addr_q    <= '0;
      uncached_q    <= 1'b0;
      beat_cnt_q    <= '0;
      buffer_q      <= '0;
      inv_pending_q <= 1'b0;
      rr_ptr_q      <= '{default: '0};
    end else begin
      state_q       <= state_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      req_addr_q    <= req_addr_d;
      uncached_q    <= uncached_d;
      beat_cnt_q    <= beat_cnt_d;
      buffer_q      <= buffer_d;
      inv_pending_q <= inv_pending_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  always_comb begin
    cpu_rdata = '0;
    if (bus.cpu_inst_req) begin
      if (state_q == END_FILL) begin
        cpu_rdata = uncached_q ? buffer_q[0] : buffer_q[req_word];
      end else if (hit) begin
        cpu_rdata = hit_line[cpu_word];
      end
    end
  end

  assign bus.cpu_inst_rdata = cpu_rdata;
  assign bus.i_stall        = (state_q != END_FILL) &&
                              ((bus.cpu_inst_req && !hit && (state_q == IDLE)) ||
                               (state_q == MISS) || (state_q == FILL));
  assign bus.araddr         = uncached_q ? req_addr_q : {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign bus.arlen          = uncached_q ? 4'd0 : 4'(LINE_WORDS - 1);
  assign bus.arvalid        = arvalid_q;
  assign bus.rready         = rready_q;

endmodule

// File: tb/tb_i_cache_assoc.sv
// Directed scenario bench for i_cache_assoc (2 ways, 128 sets, 8-word lines).
module tb_i_cache_assoc;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  i_cache_assoc_if bus ();

  i_cache_assoc #(
    .WAYS           (2),
    .INDEX_WIDTH    (7),
    .LINE_WORDS     (8),
    .UNCACHED_KSEG1 (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // memory image seen through the read arbiter
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic idle_inputs();
    bus.cpu_inst_req  = 1'b0;
    bus.cpu_inst_addr = '0;
    bus.longest_stall = 1'b0;
    bus.inv_all       = 1'b0;
    bus.arready       = 1'b0;
    bus.rdata         = '0;
    bus.rlast         = 1'b0;
    bus.rvalid        = 1'b0;
  endtask

  // plays the read arbiter for one burst; leaves time at +1 in END_FILL
  task automatic serve(input logic [31:0] base, input int n_beats, input int inv_beat,
                       output logic [31:0] got_addr, output logic [3:0] got_len,
                       output bit rdy_ok, output bit timed_out);
    int waitc;
    waitc     = 0;
    timed_out = 1'b0;
    rdy_ok    = 1'b1;
    got_addr  = '0;
    got_len   = '0;
    while (bus.arvalid !== 1'b1 && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (bus.arvalid !== 1'b1) begin
      timed_out = 1'b1;
      return;
    end
    got_addr = bus.araddr;
    got_len  = bus.arlen;
    bus.arready = 1'b1;
    @(posedge clk); #1;
    bus.arready = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      bus.rvalid  = 1'b1;
      bus.rdata   = word_at(base + 32'(4 * i));
      bus.rlast   = (i == n_beats - 1);
      bus.inv_all = (i == inv_beat);
      if (bus.rready !== 1'b1) rdy_ok = 1'b0;
      @(posedge clk); #1;
    end
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.inv_all = 1'b0;
    bus.rdata   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.arvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_arvalid: got %b expected 0", bus.arvalid); end
    checks++; if (bus.rready !== 1'b0) begin failures++; $display("[TB] FAIL reset_rready: got %b expected 0", bus.rready); end
    checks++; if (bus.i_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.i_stall); end
    checks++; if (bus.cpu_inst_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.cpu_inst_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    logic [31:0] a; logic [3:0] l; bit rok, to;
    @(posedge clk); #1;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'h0000_1000; #1;
    checks++; if (bus.i_stall !== 1'b1) begin failures++; $display("[TB] FAIL cold_stall: got %b expected 1", bus.i_stall); end
    serve(32'h0000_1000, 8, -1, a, l, rok, to);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL cold_arvalid_timeout: got %b expected 0", to); end
    checks++; if (a !== 32'h0000_1000) begin failures++; $display("[TB] FAIL cold_araddr: got %h expected 00001000", a); end
    checks++; if (l !== 4'd7) begin failures++; $display("[TB] FAIL cold_arlen: got %0d expected 7", l); end
    checks++; if (rok !== 1'b1) begin failures++; $display("[TB] FAIL cold_rready: got %b expected 1", rok); end
    checks++; if (bus.cpu_inst_rdata !== word_at(32'h0000_1000)) begin failures++; $display("[TB] FAIL cold_end_data: got %h expected %h", bus.cpu_inst_rdata, word_at(32'h0000_1000)); end
    checks++; if (bus.i_stall !== 1'b0) begin failures++; $display("[TB] FAIL cold_end_stall: got %b expected 0", bus.i_stall); end
    @(posedge clk); #1;
    bus.cpu_inst_addr = 32'h0000_1004; #1;
    checks++; if (bus.i_stall !== 1'b0) begin failures++; $display("[TB] FAIL cold_hit_stall: got %b expected 0", bus.i_stall); end
    checks++; if (bus.cpu_inst_rdata !== word_at(32'h0000_1004)) begin failures++; $display("[TB] FAIL cold_hit_data: got %h expected %h", bus.cpu_inst_rdata, word_at(32'h0000_1004)); end
    bus.cpu_inst_req = 1'b0; #1;
    checks++; if (bus.cpu_inst_rdata !== 32'h0) begin failures++; $display("[TB] FAIL noreq_rdata: got %h expected 0", bus.cpu_inst_rdata); end
  endtask

  task automatic test_two_way_evict();
    logic [31:0] a; logic [3:0] l; bit rok, to;
    @(posedge clk); #1;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'h0001_1000; #1;
    checks++; if (bus.i_stall !== 1'b1) begin failures++; $display("[TB] FAIL way1_stall: got %b expected 1", bus.i_stall); end
    serve(32'h0001_1000, 8, -1, a, l, rok, to);
    checks++; if (to !== 1'b0 || a !== 32'h0001_1000) begin failures++; $display("[TB] FAIL way1_araddr: got %h timeout %b expected 00011000", a, to); end
    @(posedge clk); #1;
    bus.cpu_inst_addr = 32'h0000_1000; #1;
    checks++; if (bus.i_stall !== 1'b0 || bus.cpu_inst_rdata !== word_at(32'h0000_1000)) begin failures++; $display("[TB] FAIL way0_hit: got stall %b data %h expected 0 %h", bus.i_stall, bus.cpu_inst_rdata, word_at(32'h0000_1000)); end
    bus.cpu_inst_addr = 32'h0001_101C; #1;
    checks++; if (bus.i_stall !== 1'b0 || bus.cpu_inst_rdata !== word_at(32'h0001_101C)) begin failures++; $display("[TB] FAIL way1_hit: got stall %b data %h expected 0 %h", bus.i_stall, bus.cpu_inst_rdata, word_at(32'h0001_101C)); end
    @(posedge clk); #1;
    bus.cpu_inst_addr = 32'h0002_1000; #1;
    checks++; if (bus.i_stall !== 1'b1) begin failures++; $display("[TB] FAIL third_stall: got %b expected 1", bus.i_stall); end
    serve(32'h0002_1000, 8, -1, a, l, rok, to);
    checks++; if (to !== 1'b0 || a !== 32'h0002_1000) begin failures++; $display("[TB] FAIL third_araddr: got %h timeout %b expected 00021000", a, to); end
    checks++; if (bus.cpu_inst_rdata !== word_at(32'h0002_1000)) begin failures++; $display("[TB] FAIL third_data: got %h expected %h", bus.cpu_inst_rdata, word_at(32'h0002_1000)); end
    @(posedge clk); #1;
    bus.cpu_inst_addr = 32'h0000_1000; #1;
    checks++; if (bus.i_stall !== 1'b1) begin failures++; $display("[TB] FAIL evicted_miss: got %b expected 1", bus.i_stall); end
    bus.cpu_inst_req = 1'b0;
    @(posedge clk); #1;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'h0001_1008; #1;
    checks++; if (bus.i_stall !== 1'b0 || bus.cpu_inst_rdata !== word_at(32'h0001_1008)) begin failures++; $display("[TB] FAIL survivor_hit: got stall %b data %h expected 0 %h", bus.i_stall, bus.cpu_inst_rdata, word_at(32'h0001_1008)); end
    bus.cpu_inst_addr = 32'h0002_1004; #1;
    checks++; if (bus.i_stall !== 1'b0 || bus.cpu_inst_rdata !== word_at(32'h0002_1004)) begin failures++; $display("[TB] FAIL newline_hit: got stall %b data %h expected 0 %h", bus.i_stall, bus.cpu_inst_rdata, word_at(32'h0002_1004)); end
    bus.cpu_inst_req = 1'b0;
  endtask

  task automatic test_uncached();
    logic [31:0] a; logic [3:0] l; bit rok, to;
    @(posedge clk); #1;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'hBFC0_0010; #1;
    checks++; if (bus.i_stall !== 1'b1) begin failures++; $display("[TB] FAIL unc_stall: got %b expected 1", bus.i_stall); end
    serve(32'hBFC0_0010, 1, -1, a, l, rok, to);
    checks++; if (to !== 1'b0 || a !== 32'hBFC0_0010) begin failures++; $display("[TB] FAIL unc_araddr: got %h timeout %b expected bfc00010", a, to); end
    checks++; if (l !== 4'd0) begin failures++; $display("[TB] FAIL unc_arlen: got %0d expected 0", l); end
    checks++; if (bus.cpu_inst_rdata !== word_at(32'hBFC0_0010) || bus.i_stall !== 1'b0) begin failures++; $display("[TB] FAIL unc_data: got %h stall %b expected %h 0", bus.cpu_inst_rdata, bus.i_stall, word_at(32'hBFC0_0010)); end
    @(posedge clk); #1;
    checks++; if (bus.i_stall !== 1'b1) begin failures++; $display("[TB] FAIL unc_refetch_miss: got %b expected 1", bus.i_stall); end
    bus.cpu_inst_req = 1'b0;
    @(posedge clk); #1;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'h0001_1000; #1;
    checks++; if (bus.i_stall !== 1'b0 || bus.cpu_inst_rdata !== word_at(32'h0001_1000)) begin failures++; $display("[TB] FAIL unc_no_alloc: got stall %b data %h expected 0 %h", bus.i_stall, bus.cpu_inst_rdata, word_at(32'h0001_1000)); end
    bus.cpu_inst_req = 1'b0;
  endtask

  task automatic test_inv_idle();
    @(posedge clk); #1;
    bus.inv_all = 1'b1;
    @(posedge clk); #1;
    bus.inv_all = 1'b0;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'h0001_1000; #1;
    checks++; if (bus.i_stall !== 1'b1) begin failures++; $display("[TB] FAIL inv_idle_miss: got %b expected 1", bus.i_stall); end
    bus.cpu_inst_req = 1'b0;
  endtask

  task automatic test_inv_pending();
    logic [31:0] a; logic [3:0] l; bit rok, to;
    @(posedge clk); #1;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'h0000_1000;
    serve(32'h0000_1000, 8, -1, a, l, rok, to);
    @(posedge clk); #1;
    checks++; if (bus.i_stall !== 1'b0) begin failures++; $display("[TB] FAIL refill_hit: got %b expected 0", bus.i_stall); end
    bus.cpu_inst_addr = 32'h0000_2000;
    serve(32'h0000_2000, 8, 3, a, l, rok, to);
    checks++; if (to !== 1'b0 || bus.cpu_inst_rdata !== word_at(32'h0000_2000) || bus.i_stall !== 1'b0) begin failures++; $display("[TB] FAIL invfill_data: got %h stall %b timeout %b expected %h 0 0", bus.cpu_inst_rdata, bus.i_stall, to, word_at(32'h0000_2000)); end
    @(posedge clk); #1;
    checks++; if (bus.i_stall !== 1'b1) begin failures++; $display("[TB] FAIL invfill_not_written: got %b expected 1", bus.i_stall); end
    bus.cpu_inst_req = 1'b0;
    @(posedge clk); #1;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'h0000_1000; #1;
    checks++; if (bus.i_stall !== 1'b1) begin failures++; $display("[TB] FAIL inv_old_line: got %b expected 1", bus.i_stall); end
    serve(32'h0000_1000, 8, -1, a, l, rok, to);
    @(posedge clk); #1;
    checks++; if (bus.i_stall !== 1'b0 || bus.cpu_inst_rdata !== word_at(32'h0000_1000)) begin failures++; $display("[TB] FAIL pending_cleared: got stall %b data %h expected 0 %h", bus.i_stall, bus.cpu_inst_rdata, word_at(32'h0000_1000)); end
    bus.cpu_inst_req = 1'b0;
  endtask

  task automatic test_longest_stall();
    logic [31:0] a; logic [3:0] l; bit rok, to;
    @(posedge clk); #1;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'h0000_3004;
    serve(32'h0000_3000, 8, -1, a, l, rok, to);
    bus.longest_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      checks++; if (bus.cpu_inst_rdata !== word_at(32'h0000_3004) || bus.i_stall !== 1'b0) begin failures++; $display("[TB] FAIL lstall_hold%0d: got %h stall %b expected %h 0", c, bus.cpu_inst_rdata, bus.i_stall, word_at(32'h0000_3004)); end
    end
    bus.longest_stall = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.i_stall !== 1'b0 || bus.cpu_inst_rdata !== word_at(32'h0000_3004) || bus.arvalid !== 1'b0) begin failures++; $display("[TB] FAIL lstall_hit: got stall %b data %h arvalid %b expected 0 %h 0", bus.i_stall, bus.cpu_inst_rdata, bus.arvalid, word_at(32'h0000_3004)); end
    bus.cpu_inst_req = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a; logic [3:0] l; bit rok, to;
    int waitc;
    @(posedge clk); #1;
    bus.cpu_inst_req = 1'b1; bus.cpu_inst_addr = 32'h0000_4000;
    waitc = 0;
    while (bus.arvalid !== 1'b1 && waitc < 20) begin @(posedge clk); #1; waitc++; end
    checks++; if (bus.arvalid !== 1'b1) begin failures++; $display("[TB] FAIL mid_arvalid_timeout: got %b expected 1", bus.arvalid); end
    bus.arready = 1'b1;
    @(posedge clk); #1;
    bus.arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rvalid = 1'b1; bus.rdata = word_at(32'h0000_4000 + 32'(4 * i));
      @(posedge clk); #1;
    end
    bus.rvalid = 1'b0;
    rst = 1'b1; #1;
    checks++; if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_outputs: got arvalid %b rready %b expected 0 0", bus.arvalid, bus.rready); end
    bus.cpu_inst_addr = 32'h0000_5008;
    @(posedge clk); #1;
    rst = 1'b0;
    serve(32'h0000_5000, 8, -1, a, l, rok, to);
    checks++; if (to !== 1'b0 || a !== 32'h0000_5000) begin failures++; $display("[TB] FAIL restart_araddr: got %h timeout %b expected 00005000", a, to); end
    checks++; if (bus.cpu_inst_rdata !== word_at(32'h0000_5008)) begin failures++; $display("[TB] FAIL restart_data: got %h expected %h", bus.cpu_inst_rdata, word_at(32'h0000_5008)); end
    @(posedge clk); #1;
    checks++; if (bus.i_stall !== 1'b0 || bus.cpu_inst_rdata !== word_at(32'h0000_5008)) begin failures++; $display("[TB] FAIL restart_hit: got stall %b data %h expected 0 %h", bus.i_stall, bus.cpu_inst_rdata, word_at(32'h0000_5008)); end
    bus.cpu_inst_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_cold_miss();
    test_two_way_evict();
    test_uncached();
    test_inv_idle();
    test_inv_pending();
    test_longest_stall();
    test_reset_mid_burst();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
